// File: rtl/dense_buf_ctrl_if.sv
// rtl/dense_buf_ctrl_if.sv - requester and buffer-side signal bundle for dense_buf_ctrl
interface dense_buf_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6
);
  logic                  clear_i;
  logic                  wr_req_i;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_gnt_o;
  logic                  rd0_req_i;
  logic                  rd1_req_i;
  logic [ADDR_WIDTH-1:0] rd0_addr_i;
  logic [ADDR_WIDTH-1:0] rd1_addr_i;
  logic                  rd0_gnt_o;
  logic                  rd1_gnt_o;
  logic                  rd0_rvalid_o;
  logic                  rd1_rvalid_o;
  logic [DATA_WIDTH-1:0] rd0_rdata_o;
  logic [DATA_WIDTH-1:0] rd1_rdata_o;
  logic                  buf_write_en_o;
  logic [ADDR_WIDTH-1:0] buf_write_addr_o;
  logic [DATA_WIDTH-1:0] buf_write_data_o;
  logic                  buf_read_en_o;
  logic [ADDR_WIDTH-1:0] buf_read_addr_o;
  logic [DATA_WIDTH-1:0] buf_read_data_i;
  logic [ADDR_WIDTH-1:0] fill_cnt_o;
  logic                  full_o;
  logic                  err_o;

  modport master (
    output clear_i, wr_req_i, wr_addr_i, wr_data_i,
    output rd0_req_i, rd1_req_i, rd0_addr_i, rd1_addr_i, buf_read_data_i,
    input  wr_gnt_o, rd0_gnt_o, rd1_gnt_o, rd0_rvalid_o, rd1_rvalid_o,
    input  rd0_rdata_o, rd1_rdata_o, buf_write_en_o, buf_write_addr_o,
    input  buf_write_data_o, buf_read_en_o, buf_read_addr_o,
    input  fill_cnt_o, full_o, err_o
  );

  modport slave (
    input  clear_i, wr_req_i, wr_addr_i, wr_data_i,
    input  rd0_req_i, rd1_req_i, rd0_addr_i, rd1_addr_i, buf_read_data_i,
    output wr_gnt_o, rd0_gnt_o, rd1_gnt_o, rd0_rvalid_o, rd1_rvalid_o,
    output rd0_rdata_o, rd1_rdata_o, buf_write_en_o, buf_write_addr_o,
    output buf_write_data_o, buf_read_en_o, buf_read_addr_o,
    output fill_cnt_o, full_o, err_o
  );
endinterface

// File: rtl/dense_buf_ctrl.sv
// rtl/dense_buf_ctrl.sv - dense operand buffer access controller
// One loader write port, two round-robin core read ports, per-entry valid bitmap.
module dense_buf_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 60
) (
  input  logic               clk,
  input  logic               rst,
  dense_buf_ctrl_if.slave    bus
);
  localparam logic [ADDR_WIDTH:0]   LIMIT     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_CNT = ADDR_WIDTH'(DEPTH);

  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] fill_q;
  logic                  err_q;
  logic                  prio_q;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];

  logic                  wr_in;
  logic                  wr_gnt;
  logic                  wr_en;
  logic [1:0]            req;
  logic [1:0]            rd_in;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic                  sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  rd_en;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  function automatic logic valid_at(input logic [DEPTH-1:0] v, input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) ? v[a] : 1'b0;
  endfunction

  assign req[0]  = bus.rd0_req_i;
  assign req[1]  = bus.rd1_req_i;
  assign addr[0] = bus.rd0_addr_i;
  assign addr[1] = bus.rd1_addr_i;

  always_comb begin
    wr_in  = in_range(bus.wr_addr_i);
    wr_gnt = bus.wr_req_i & ~bus.clear_i & ~rst;
    wr_en  = wr_gnt & wr_in;
    rd_in  = '0;
    elig   = '0;
    for (int k = 0; k < 2; k++) begin
      rd_in[k] = in_range(addr[k]);
      // Out-of-range reads are granted so they can be flagged and answered with zero.
      elig[k]  = req[k] & ~bus.clear_i & ~rst &
                 (~rd_in[k] | valid_at(valid_q, addr[k]) |
                  (wr_en & (bus.wr_addr_i == addr[k])));
    end
    gnt[0]   = elig[0] & (~elig[1] | ~prio_q);
    gnt[1]   = elig[1] & (~elig[0] | prio_q);
    sel      = gnt[1];
    sel_addr = addr[sel];
    rd_en    = (|gnt) & rd_in[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      prio_q     <= 1'b0;
      rvalid_q   <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q <= gnt;
      for (int k = 0; k < 2; k++) begin
        if (gnt[k]) rdata_q[k] <= rd_in[k] ? bus.buf_read_data_i : '0;
      end
      if (|gnt) prio_q <= gnt[0];
      if (bus.clear_i) begin
        valid_q <= '0;
        fill_q  <= '0;
        err_q   <= 1'b0;
      end else begin
        if (wr_en && !valid_q[bus.wr_addr_i]) begin
          valid_q[bus.wr_addr_i] <= 1'b1;
          fill_q                 <= fill_q + ADDR_WIDTH'(1);
        end
        if ((wr_gnt && !wr_in) || (|(gnt & ~rd_in))) err_q <= 1'b1;
      end
    end
  end

  assign bus.wr_gnt_o         = wr_gnt;
  assign bus.rd0_gnt_o        = gnt[0];
  assign bus.rd1_gnt_o        = gnt[1];
  assign bus.rd0_rvalid_o     = rvalid_q[0];
  assign bus.rd1_rvalid_o     = rvalid_q[1];
  assign bus.rd0_rdata_o      = rdata_q[0];
  assign bus.rd1_rdata_o      = rdata_q[1];
  assign bus.buf_write_en_o   = wr_en;
  assign bus.buf_write_addr_o = wr_en ? bus.wr_addr_i : '0;
  assign bus.buf_write_data_o = wr_en ? bus.wr_data_i : '0;
  assign bus.buf_read_en_o    = rd_en;
  assign bus.buf_read_addr_o  = rd_en ? sel_addr : '0;
  assign bus.fill_cnt_o       = fill_q;
  assign bus.full_o           = (fill_q == DEPTH_CNT);
  assign bus.err_o            = err_q;
endmodule

// File: tb/tb_dense_buf_ctrl.sv
// tb/tb_dense_buf_ctrl.sv - directed self-checking bench for dense_buf_ctrl
module tb_dense_buf_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [127:0] mem [60];

  dense_buf_ctrl_if #(.DATA_WIDTH(128), .ADDR_WIDTH(6)) bus ();

  dense_buf_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural buffer: registered write, combinational read with write-to-read forwarding.
  always @(posedge clk) begin
    if (bus.buf_write_en_o) mem[bus.buf_write_addr_o] <= bus.buf_write_data_o;
  end

  always_comb begin
    bus.buf_read_data_i = '0;
    if (bus.buf_write_en_o && bus.buf_write_addr_o == bus.buf_read_addr_o)
      bus.buf_read_data_i = bus.buf_write_data_o;
    else if (bus.buf_read_addr_o < 6'd60)
      bus.buf_read_data_i = mem[bus.buf_read_addr_o];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    bus.clear_i    = 1'b0;
    bus.wr_req_i   = 1'b0;
    bus.rd0_req_i  = 1'b0;
    bus.rd1_req_i  = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [127:0] d);
    bus.wr_req_i  = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
  endtask

  function automatic logic [127:0] pat(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {16{b}};
  endfunction

  initial begin
    for (int i = 0; i < 60; i++) mem[i] = '0;
    rst = 1'b1;
    idle();
    bus.wr_addr_i  = 6'd2;
    bus.wr_data_i  = '1;
    bus.rd0_addr_i = 6'd2;
    bus.rd1_addr_i = 6'd2;
    bus.wr_req_i   = 1'b1;
    bus.rd0_req_i  = 1'b1;
    bus.rd1_req_i  = 1'b1;
    tick();
    tick();
    settle();
    check("rst_wr_gnt", bus.wr_gnt_o, 0);
    check("rst_rd0_gnt", bus.rd0_gnt_o, 0);
    check("rst_rd1_gnt", bus.rd1_gnt_o, 0);
    check("rst_buf_wen", bus.buf_write_en_o, 0);
    check("rst_buf_ren", bus.buf_read_en_o, 0);
    check("rst_rvalid0", bus.rd0_rvalid_o, 0);
    check("rst_rdata0", bus.rd0_rdata_o, 0);
    check("rst_fill", bus.fill_cnt_o, 0);
    check("rst_full", bus.full_o, 0);
    check("rst_err", bus.err_o, 0);
    idle();
    rst = 1'b0;
    tick();

    wr(6'd3, pat(8'hA5));
    settle();
    check("t1_wr_gnt", bus.wr_gnt_o, 1);
    check("t1_buf_wen", bus.buf_write_en_o, 1);
    check("t1_buf_waddr", bus.buf_write_addr_o, 3);
    check("t1_buf_wdata", bus.buf_write_data_o, pat(8'hA5));
    tick();
    bus.wr_req_i = 1'b0;
    check("t1_fill", bus.fill_cnt_o, 1);
    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd3;
    settle();
    check("t1_rd0_gnt", bus.rd0_gnt_o, 1);
    check("t1_buf_ren", bus.buf_read_en_o, 1);
    check("t1_buf_raddr", bus.buf_read_addr_o, 3);
    tick();
    bus.rd0_req_i = 1'b0;
    check("t1_rvalid0", bus.rd0_rvalid_o, 1);
    check("t1_rdata0", bus.rd0_rdata_o, pat(8'hA5));
    tick();
    check("t1_rvalid0_drop", bus.rd0_rvalid_o, 0);
    check("t1_rdata0_hold", bus.rd0_rdata_o, pat(8'hA5));

    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd7;
    settle();
    check("t2_stall_gnt", bus.rd0_gnt_o, 0);
    check("t2_stall_ren", bus.buf_read_en_o, 0);
    tick();
    check("t2_stall_rvalid", bus.rd0_rvalid_o, 0);
    wr(6'd7, pat(8'h11));
    settle();
    check("t2_byp_wr_gnt", bus.wr_gnt_o, 1);
    check("t2_byp_rd0_gnt", bus.rd0_gnt_o, 1);
    check("t2_byp_raddr", bus.buf_read_addr_o, 7);
    tick();
    idle();
    check("t2_byp_rvalid", bus.rd0_rvalid_o, 1);
    check("t2_byp_rdata", bus.rd0_rdata_o, pat(8'h11));
    check("t2_fill", bus.fill_cnt_o, 2);

    wr(6'd0, pat(8'hC0));
    tick();
    wr(6'd1, pat(8'hC1));
    tick();
    bus.wr_req_i   = 1'b0;
    bus.rd1_req_i  = 1'b1;
    bus.rd1_addr_i = 6'd1;
    settle();
    check("t3_rd1_solo_gnt", bus.rd1_gnt_o, 1);
    tick();
    check("t3_rd1_solo_rdata", bus.rd1_rdata_o, pat(8'hC1));
    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd0;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("t3_gnt0_c%0d", i), bus.rd0_gnt_o, (i % 2) == 0);
      check($sformatf("t3_gnt1_c%0d", i), bus.rd1_gnt_o, (i % 2) == 1);
      tick();
      check($sformatf("t3_rvalid0_c%0d", i), bus.rd0_rvalid_o, (i % 2) == 0);
      check($sformatf("t3_rvalid1_c%0d", i), bus.rd1_rvalid_o, (i % 2) == 1);
      if (i % 2 == 0) check($sformatf("t3_rdata0_c%0d", i), bus.rd0_rdata_o, pat(8'hC0));
      else            check($sformatf("t3_rdata1_c%0d", i), bus.rd1_rdata_o, pat(8'hC1));
    end
    idle();

    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd3;
    bus.rd1_req_i  = 1'b1;
    bus.rd1_addr_i = 6'd20;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t4_gnt0_c%0d", i), bus.rd0_gnt_o, 1);
      check($sformatf("t4_gnt1_c%0d", i), bus.rd1_gnt_o, 0);
      tick();
      check($sformatf("t4_rdata0_c%0d", i), bus.rd0_rdata_o, pat(8'hA5));
      check($sformatf("t4_rvalid1_c%0d", i), bus.rd1_rvalid_o, 0);
    end
    idle();

    for (int a = 0; a < 59; a++) begin
      wr(6'(a), pat(a));
      tick();
    end
    check("t5_fill59", bus.fill_cnt_o, 59);
    check("t5_notfull59", bus.full_o, 0);
    wr(6'd59, pat(59));
    tick();
    check("t5_fill60", bus.fill_cnt_o, 60);
    check("t5_full60", bus.full_o, 1);
    wr(6'd0, pat(8'h77));
    tick();
    check("t5_rewrite_fill", bus.fill_cnt_o, 60);
    check("t5_err_clean", bus.err_o, 0);
    wr(6'd60, pat(8'hEE));
    settle();
    check("t5_oor_wr_gnt", bus.wr_gnt_o, 1);
    check("t5_oor_buf_wen", bus.buf_write_en_o, 0);
    tick();
    bus.wr_req_i = 1'b0;
    check("t5_oor_err", bus.err_o, 1);
    check("t5_oor_fill", bus.fill_cnt_o, 60);
    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd59;
    settle();
    check("t5_rd59_gnt", bus.rd0_gnt_o, 1);
    tick();
    check("t5_rd59_rdata", bus.rd0_rdata_o, pat(59));
    bus.rd0_addr_i = 6'd0;
    settle();
    tick();
    check("t5_rd0_rewritten", bus.rd0_rdata_o, pat(8'h77));
    bus.rd0_addr_i = 6'd63;
    settle();
    check("t5_oor_rd_gnt", bus.rd0_gnt_o, 1);
    check("t5_oor_rd_ren", bus.buf_read_en_o, 0);
    tick();
    idle();
    check("t5_oor_rd_rvalid", bus.rd0_rvalid_o, 1);
    check("t5_oor_rd_rdata", bus.rd0_rdata_o, 0);

    wr(6'd5, pat(8'h55));
    bus.rd0_req_i  = 1'b1;
    bus.rd0_addr_i = 6'd3;
    bus.rd1_req_i  = 1'b1;
    bus.rd1_addr_i = 6'd4;
    bus.clear_i    = 1'b1;
    settle();
    check("t6_clr_wr_gnt", bus.wr_gnt_o, 0);
    check("t6_clr_gnt0", bus.rd0_gnt_o, 0);
    check("t6_clr_gnt1", bus.rd1_gnt_o, 0);
    check("t6_clr_buf_wen", bus.buf_write_en_o, 0);
    check("t6_clr_buf_ren", bus.buf_read_en_o, 0);
    tick();
    bus.clear_i  = 1'b0;
    bus.wr_req_i = 1'b0;
    settle();
    check("t6_fill", bus.fill_cnt_o, 0);
    check("t6_full", bus.full_o, 0);
    check("t6_err", bus.err_o, 0);
    check("t6_stall_gnt0", bus.rd0_gnt_o, 0);
    check("t6_stall_gnt1", bus.rd1_gnt_o, 0);
    check("t6_stall_ren", bus.buf_read_en_o, 0);
    tick();
    check("t6_rvalid0", bus.rd0_rvalid_o, 0);
    check("t6_rvalid1", bus.rd1_rvalid_o, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dense_buf_ctrl.md
# dense_buf_ctrl

Access controller for the 60-entry × 128-bit dense operand buffer in the 16x16 int8 dual-core array. It owns the buffer's single write port and single read port. It serves one write requester (the DMA/loader) and two read requesters (core 0 and core 1), arbitrating the two cores round-robin. It keeps a per-entry valid bitmap so no core reads an entry before it has been loaded, and returns registered read data with fixed latency.

## Interface
Parameters:
- DATA_WIDTH, 128, entry width
- ADDR_WIDTH, 6, address width
- DEPTH, 60, number of entries; legal addresses are 0..DEPTH-1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- clear_i  in  1  invalidate all entries and clear err_o
- wr_req_i  in  1  loader write request
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  DATA_WIDTH  write data
- wr_gnt_o  out  1  write accepted this cycle
- rd0_req_i / rd1_req_i  in  1  core read request
- rd0_addr_i / rd1_addr_i  in  ADDR_WIDTH  core read address
- rd0_gnt_o / rd1_gnt_o  out  1  read accepted this cycle
- rd0_rvalid_o / rd1_rvalid_o  out  1  read data valid
- rd0_rdata_o / rd1_rdata_o  out  DATA_WIDTH  read data
- buf_write_en_o  out  1  to buffer write_en_i
- buf_write_addr_o  out  ADDR_WIDTH  to buffer write_addr_i
- buf_write_data_o  out  DATA_WIDTH  to buffer write_data_i
- buf_read_en_o  out  1  to buffer read_en_i
- buf_read_addr_o  out  ADDR_WIDTH  to buffer read_addr_i
- buf_read_data_i  in  DATA_WIDTH  from buffer read_data_o (combinational)
- fill_cnt_o  out  ADDR_WIDTH  number of valid entries, 0..DEPTH
- full_o  out  1  fill_cnt_o == DEPTH
- err_o  out  1  sticky out-of-range access flag

## Operation
- Handshake: a request is held with a stable address/data until its gnt is high in the same cycle. Grants are combinational from the current requests and state.
- Clear cycle: while clear_i=1, no grants are issued. On the next edge, the bitmap is zeroed, fill_cnt becomes 0 and err becomes 0.
- Write: wr_gnt_o = wr_req_i & ~clear_i.
  - In range: buf_write_en_o=1 with the address and data passed through. The valid bit is set at the edge. fill_cnt increments only if the bit was previously 0.
  - Out of range (addr ≥ DEPTH): the write is granted but buf_write_en_o=0, and err is set.
- Read eligibility of core k: req, ~clear_i, and one of:
  - address out of range;
  - valid[addr]=1;
  - a write to the same in-range address is granted this cycle. This is the write-to-read bypass, which the buffer forwards combinationally.
- Arbitration: at most one read grant per cycle.
  - If both cores are eligible, the core with priority wins. Priority then passes to the other core.
  - If one core is eligible, it is granted. Priority then passes to the other core.
  - Priority resets to core 0.
  - An ineligible requester waits with no grant. It does not block the other core.
- Granted in-range read: buf_read_en_o=1 with buf_read_addr_o=addr. buf_read_data_i is captured into that core's rdata register.
- Granted out-of-range read: buf_read_en_o=0, rdata captures 0, err is set.
- A write grant and a read grant may occur in the same cycle.
- buf_* outputs are 0 when there is no corresponding grant.

## Timing
- Reset values: every gnt, rvalid and buf_* output is 0, rdata=0, fill_cnt=0, full=0, err=0. The bitmap is all 0 and priority is core 0. Reset overrides clear_i and all requests.
- Read latency: rdk_rvalid_o=1 exactly one cycle after rdk_gnt_o, for one cycle, carrying the data sampled in the grant cycle.
- rdata holds its last value while rvalid=0.
- Back-to-back reads from the same core are allowed every cycle when the other core is idle.
- fill_cnt_o and full_o update at the edge after the write grant.
- err_o is sticky until rst or clear_i.

## Test plan
- Reset, then write 0xA5..A5 to address 3. Core 0 reads address 3 the next cycle. Expected: gnt in the same cycle, rvalid next cycle with data 0xA5..A5, fill_cnt=1.
- Core 0 reads address 7 before it has been written. Expected: no grant and no buffer read. The loader then writes 7 = 0x11..11. Expected: the same-cycle bypass grants core 0, and rvalid next cycle returns 0x11..11.
- Both cores continuously request valid addresses 0 and 1 for 6 cycles. Expected: grants alternate 0,1,0,1,0,1, and each rvalid carries the matching data.
- Core 1 requests an unwritten address while core 0 requests a valid one. Expected: core 0 is granted every cycle and core 1 is never granted.
- Write all 60 addresses, then rewrite address 0. Expected: fill_cnt=60 and full=1 after the 60th write, with no change on the rewrite. Write address 60. Expected: granted, buf_write_en_o=0, err=1.
- Assert clear_i while both cores and the loader are requesting. Expected: no grants that cycle. Next cycle: fill_cnt=0, full=0, err=0, and reads of any address stall.
